namuru_if_player: RTL
=====================

Name: namuru_if_player

Overview:
- CSR-programmed GPS IF sample playback source: the transmit-side counterpart of the correlator's gps_rec_sign/gps_rec_mag sample input.
- Software pushes packed 2-bit sign/mag samples into a FIFO; the block replays them at a programmable rate as a sign/mag stream plus a sample strobe.
- Sits beside namuru on the CSR bus. Used for lab/regression testing of the time base and tracking channels without an RF front-end.

Parameters:
- csr_addr, 5'h0, CSR bank select, matched against csr_a[14:10].
- fifo_depth_log2, 4, FIFO depth in 32-bit words is 2**fifo_depth_log2 (default 16).

Ports:
- sys_clk  in  1  system clock; the only clock.
- sys_rst  in  1  synchronous, active-high reset.
- csr_a  in  15  CSR address; [14:10] bank, [2:0] register index.
- csr_we  in  1  CSR write strobe.
- csr_di  in  32  CSR write data.
- csr_do  out  32  CSR read data; registered, 1-cycle latency, 0 when bank not selected.
- if_sign  out  1  played sample sign bit.
- if_mag  out  1  played sample magnitude bit.
- if_strobe  out  1  1-cycle pulse; if_sign/if_mag updated in this same cycle.
- irq  out  1  level: enable=1 and FIFO level <= depth/2.

Behaviour:
- Reset: all outputs 0; FIFO empty; state IDLE; ctrl=0; div=0; sticky flags=0; played counter=0.
- Registers (index = csr_a[2:0]):
  - 0 ctrl: bit0 enable, bit1 loop, bit2 flush (write-1 pulse, reads 0).
  - 1 div[15:0]: strobe period = div+1 cycles; div=0 gives a strobe every cycle.
  - 2 data: write pushes a word; reads 0.
  - 3 status: [fifo_depth_log2:0] level, [8] underrun, [9] overflow, [11:10] state (0 IDLE, 1 PLAY, 2 UNDERRUN). Writing 1 to bit 8 or 9 clears that flag.
  - 4 played[31:0]: count of emitted strobes, wraps at 2**32; any write clears it.
- Word packing: sample k is bits [2k+1:2k], played k=0 first. Bit 2k = sign, bit 2k+1 = mag.
- FSM:
  - IDLE: counter held at 0, no strobes, if_sign/if_mag = 0. If enable=1 and level>0: pop word into shift register, sample index=0, counter=div, go PLAY.
  - PLAY: counter decrements each cycle. When counter=0:
    - emit shreg[1:0] and pulse if_strobe; shift right by 2; index++; played++; reload counter=div.
    - On emitting index 15: if level>0, pop the next word in the same cycle (gapless, period stays exactly div+1). Otherwise go UNDERRUN and set underrun.
  - UNDERRUN: if_sign/if_mag hold the last sample; no strobes. When level>0: pop, index=0, counter=div, go PLAY. The first strobe comes div+1 cycles after the pop.
- Loop mode (loop=1): each popped word is re-pushed to the FIFO tail in the same cycle, so level is unchanged. CSR data writes while enable=1 and loop=1 are dropped and set overflow.
- Push rules:
  - A push when level=depth is dropped and sets overflow, unless a pop occurs in the same cycle; then it is accepted.
  - Push and pop in the same cycle leave level unchanged.
- enable cleared: next state IDLE from any state; shift register discarded; FIFO contents kept; outputs forced to 0.
- flush: FIFO emptied (level=0), state forced to IDLE; enable is unaffected.
  - If enable=1 after the flush, the block waits in IDLE for the next push.
  - Flush and push in the same cycle: flush wins, the pushed word is discarded.
- Mid-operation sys_rst: everything returns to reset values on the next edge, regardless of state.
- CSR read of a register reflects the value before any write issued in the same cycle.

Test Plan:
- Reset, write data=0x000000E4, div=3, enable=1 -> 16 strobes, exactly 4 cycles apart. First four samples are (sign,mag) = (0,0),(1,0),(0,1),(1,1); remaining twelve are (0,0). Then state=UNDERRUN, status bit8=1, played=16.
- Push 2 words, div=0, enable -> 32 consecutive strobes with no gap at the word boundary; then UNDERRUN. Push a third word -> first new strobe exactly 1 cycle after the pop.
- Push 17 words with enable=0 (depth 16) -> level=16, overflow=1. Write 0x200 to status -> overflow=0.
- loop=1 with 1 word 0xAAAAAAAA, div=1 -> if_mag=1, if_sign=0 on every strobe, a strobe every 2 cycles indefinitely. Level stays 1, underrun stays 0, played increments per strobe.
- During PLAY: clear enable -> IDLE next cycle, outputs 0, level preserved. Then flush -> level=0. Assert sys_rst during PLAY -> all reset values next cycle.
- irq: enable=1 with 9 words -> irq=0. After the first word pops (level=8) -> irq=1. Write enable=0 -> irq=0.

Source files
------------

// File: rtl/namuru_if_player.sv
// namuru_if_player: CSR-fed FIFO of packed 2-bit sign/mag IF samples, replayed
// at a programmable rate as if_sign/if_mag with a one-cycle sample strobe.
module namuru_if_player #(
    parameter logic [4:0] csr_addr        = 5'h0,
    parameter int         fifo_depth_log2 = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [14:0] csr_a,
    input  logic        csr_we,
    input  logic [31:0] csr_di,
    output logic [31:0] csr_do,
    output logic        if_sign,
    output logic        if_mag,
    output logic        if_strobe,
    output logic        irq
);
    // state    | meaning
    // IDLE     | stopped, outputs 0, waits for enable and a non-empty FIFO
    // PLAY     | down-counter running, one sample every div+1 cycles
    // UNDERRUN | word exhausted with FIFO empty, last sample held
    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, UNDERRUN = 2'd2} state_t;

    localparam int          LW         = fifo_depth_log2;
    localparam int          DEPTH      = 2 ** fifo_depth_log2;
    localparam logic [LW:0] LEVEL_FULL = (LW + 1)'(DEPTH);
    localparam logic [LW:0] LEVEL_HALF = (LW + 1)'(DEPTH / 2);

    state_t        state_q, state_d;
    logic          enable_q, enable_d, loop_q, loop_d;
    logic [15:0]   div_q, div_d, cnt_q, cnt_d;
    logic          underrun_q, underrun_d, overflow_q, overflow_d;
    logic [31:0]   played_q, played_d, shreg_q, shreg_d, csr_do_q, csr_do_d;
    logic [3:0]    idx_q, idx_d;
    logic          sign_q, sign_d, mag_q, mag_d, strobe_q, strobe_d;
    logic [LW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [LW:0]   level_q, level_d;
    logic [31:0]   mem_q [DEPTH];

    logic        bank_sel, wr, wr_ctrl, wr_div, wr_data, wr_status, wr_played, flush;
    logic [2:0]  reg_idx;
    logic        pop, push_csr, push_loop, push_req, push_ok, push_en;
    logic        underrun_set, overflow_set, played_inc;
    logic [31:0] pop_word, push_word;
    logic        unused_addr;

    assign bank_sel    = (csr_a[14:10] == csr_addr);
    assign reg_idx     = csr_a[2:0];
    assign wr          = csr_we & bank_sel;
    assign wr_ctrl     = wr && (reg_idx == 3'd0);
    assign wr_div      = wr && (reg_idx == 3'd1);
    assign wr_data     = wr && (reg_idx == 3'd2);
    assign wr_status   = wr && (reg_idx == 3'd3);
    assign wr_played   = wr && (reg_idx == 3'd4);
    assign flush       = wr_ctrl & csr_di[2];
    assign unused_addr = ^csr_a[9:3];

    always_comb begin
        enable_d = enable_q;
        loop_d   = loop_q;
        div_d    = div_q;
        if (wr_ctrl) begin
            enable_d = csr_di[0];
            loop_d   = csr_di[1];
        end
        if (wr_div) div_d = csr_di[15:0];
    end

    assign pop_word = mem_q[rd_ptr_q];

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        sign_d       = sign_q;
        mag_d        = mag_q;
        strobe_d     = 1'b0;
        pop          = 1'b0;
        underrun_set = 1'b0;
        played_inc   = 1'b0;
        if (flush || !enable_d) begin
            state_d = IDLE;
            shreg_d = '0;
            idx_d   = '0;
            cnt_d   = '0;
            sign_d  = 1'b0;
            mag_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d  = '0;
                    sign_d = 1'b0;
                    mag_d  = 1'b0;
                    // start one cycle after enable lands so the pre-pop level is visible
                    if (enable_q && level_q != '0) begin
                        pop     = 1'b1;
                        shreg_d = pop_word;
                        idx_d   = '0;
                        cnt_d   = div_q;
                        state_d = PLAY;
                    end
                end
                PLAY: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 16'd1;
                    end else begin
                        strobe_d   = 1'b1;
                        sign_d     = shreg_q[0];
                        mag_d      = shreg_q[1];
                        shreg_d    = shreg_q >> 2;
                        idx_d      = idx_q + 4'd1;
                        cnt_d      = div_q;
                        played_inc = 1'b1;
                        if (idx_q == 4'd15) begin
                            if (level_q != '0) begin
                                pop     = 1'b1;
                                shreg_d = pop_word;
                                idx_d   = '0;
                            end else begin
                                state_d      = UNDERRUN;
                                underrun_set = 1'b1;
                            end
                        end
                    end
                end
                UNDERRUN: begin
                    if (level_q != '0) begin
                        pop     = 1'b1;
                        shreg_d = pop_word;
                        idx_d   = '0;
                        cnt_d   = div_q;
                        state_d = PLAY;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        push_csr     = wr_data && !(enable_q && loop_q);
        push_loop    = pop && loop_q;
        push_req     = push_csr || push_loop;
        push_ok      = push_req && ((level_q != LEVEL_FULL) || pop);
        push_en      = push_ok && !flush;
        push_word    = push_loop ? pop_word : csr_di;
        overflow_set = (wr_data && enable_q && loop_q) || (push_req && !push_ok);
        rd_ptr_d     = rd_ptr_q + LW'(pop);
        wr_ptr_d     = wr_ptr_q + LW'(push_en);
        level_d      = level_q;
        case ({push_en, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            level_d  = '0;
        end
    end

    always_comb begin
        underrun_d = underrun_q;
        overflow_d = overflow_q;
        played_d   = played_q;
        if (wr_status && csr_di[8]) underrun_d = 1'b0;
        if (wr_status && csr_di[9]) overflow_d = 1'b0;
        if (underrun_set) underrun_d = 1'b1;
        if (overflow_set) overflow_d = 1'b1;
        if (wr_played) played_d = '0;
        else if (played_inc) played_d = played_q + 32'd1;
    end

    always_comb begin
        csr_do_d = '0;
        if (bank_sel) begin
            case (reg_idx)
                3'd0: csr_do_d = {30'd0, loop_q, enable_q};
                3'd1: csr_do_d = {16'd0, div_q};
                3'd3: begin
                    csr_do_d[LW:0]  = level_q;
                    csr_do_d[8]     = underrun_q;
                    csr_do_d[9]     = overflow_q;
                    csr_do_d[11:10] = state_q;
                end
                3'd4:    csr_do_d = played_q;
                default: csr_do_d = '0;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            enable_q   <= 1'b0;
            loop_q     <= 1'b0;
            div_q      <= '0;
            cnt_q      <= '0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
            played_q   <= '0;
            shreg_q    <= '0;
            idx_q      <= '0;
            sign_q     <= 1'b0;
            mag_q      <= 1'b0;
            strobe_q   <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            csr_do_q   <= '0;
        end else begin
            state_q    <= state_d;
            enable_q   <= enable_d;
            loop_q     <= loop_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
            played_q   <= played_d;
            shreg_q    <= shreg_d;
            idx_q      <= idx_d;
            sign_q     <= sign_d;
            mag_q      <= mag_d;
            strobe_q   <= strobe_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            csr_do_q   <= csr_do_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push_en) mem_q[wr_ptr_q] <= push_word;
    end

    assign csr_do    = csr_do_q;
    assign if_sign   = sign_q;
    assign if_mag    = mag_q;
    assign if_strobe = strobe_q;
    assign irq       = enable_q && (level_q <= LEVEL_HALF);
endmodule
